// File: rtl/fmac_fifo_wr_arb.sv
// fmac_fifo_wr_arb
// Packet-granular round-robin arbiter that shares one FIFO write port
// between two word sources. A requester is granted only when its whole
// packet (plus a small headroom margin) fits in the FIFO. Once granted, it
// owns the port until its last word is written, so packets never interleave.
module fmac_fifo_wr_arb #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 4096,
    parameter int PTR    = 12,
    parameter int MARGIN = 2
) (
    input  logic             i_clk,
    input  logic             i_aclr,
    input  logic             i_req0,
    input  logic             i_req1,
    input  logic [PTR:0]     i_len0,
    input  logic [PTR:0]     i_len1,
    input  logic             i_valid0,
    input  logic             i_valid1,
    input  logic [WIDTH-1:0] i_data0,
    input  logic [WIDTH-1:0] i_data1,
    output logic             o_gnt0,
    output logic             o_gnt1,
    output logic             o_acc0,
    output logic             o_acc1,
    output logic             o_fifo_wrreq,
    output logic [WIDTH-1:0] o_fifo_data,
    input  logic [PTR:0]     i_fifo_wrusedw,
    input  logic             i_fifo_wrfull,
    output logic             o_pkt_done,
    output logic             o_pkt_src,
    output logic             o_busy,
    output logic             o_err_len
);

    // Largest fill level (after adding a packet) that still leaves MARGIN free.
    localparam logic [PTR+1:0] LIMIT = (PTR+2)'(DEPTH - MARGIN);
    localparam logic [PTR:0]   ONE   = (PTR+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic [1:0]     r_gnt;
    logic [1:0]     w_gnt_next;
    logic           r_idx;
    logic           w_idx_next;
    logic [PTR:0]   r_cnt;
    logic [PTR:0]   w_cnt_next;
    logic [PTR:0]   r_len;
    logic [PTR:0]   w_len_next;
    logic           r_last;
    logic           w_last_next;
    logic           r_pkt_done;
    logic           w_pkt_done_next;
    logic           r_pkt_src;
    logic           w_pkt_src_next;
    logic           r_err_len;
    logic           w_err_len_next;

    // Per-requester views of the inputs so both sides share one code path.
    logic [1:0]     w_req;
    logic [1:0]     w_valid;
    logic [PTR:0]   w_len   [2];
    logic [PTR+1:0] w_sum   [2];
    logic [1:0]     w_legal;
    logic [1:0]     w_fits;
    logic [1:0]     w_elig;
    logic [1:0]     w_illegal;
    logic [1:0]     w_acc;

    logic           w_fav;
    logic           w_oth;
    logic           w_pick_vld;
    logic           w_pick_idx;
    logic [WIDTH-1:0] w_data;

    assign w_req    = {i_req1, i_req0};
    assign w_valid  = {i_valid1, i_valid0};
    assign w_len[0] = i_len0;
    assign w_len[1] = i_len1;

    // Length legality, space check and word acceptance per requester.
    // The fill sum is one bit wider than usedw/len so it cannot wrap.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign w_legal[gi]   = (w_len[gi] != '0) && ({1'b0, w_len[gi]} <= LIMIT);
            assign w_sum[gi]     = {1'b0, i_fifo_wrusedw} + {1'b0, w_len[gi]};
            assign w_fits[gi]    = (w_sum[gi] <= LIMIT);
            assign w_elig[gi]    = w_req[gi] & w_legal[gi] & w_fits[gi];
            assign w_illegal[gi] = w_req[gi] & ~w_legal[gi];
            assign w_acc[gi]     = r_gnt[gi] & w_valid[gi] & ~i_fifo_wrfull;
        end
    endgenerate

    // The requester not served last is favoured.
    assign w_fav = ~r_last;
    assign w_oth = r_last;

    // Round-robin pick. A favoured requester with a legal length but no room
    // blocks the other one, so a big packet cannot be starved by small ones.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = w_fav;
        if (w_req[w_fav] && w_legal[w_fav]) begin
            w_pick_vld = w_fits[w_fav];
            w_pick_idx = w_fav;
        end else if (w_elig[w_oth]) begin
            w_pick_vld = 1'b1;
            w_pick_idx = w_oth;
        end
    end

    // Next-state and next-register values for the IDLE/XFER/GAP sequence.
    always_comb begin
        w_state_next    = r_state;
        w_gnt_next      = r_gnt;
        w_idx_next      = r_idx;
        w_cnt_next      = r_cnt;
        w_len_next      = r_len;
        w_last_next     = r_last;
        w_pkt_done_next = 1'b0;
        w_pkt_src_next  = r_pkt_src;
        w_err_len_next  = r_err_len | (|w_illegal);
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_state_next = ST_XFER;
                    w_gnt_next   = w_pick_idx ? 2'b10 : 2'b01;
                    w_idx_next   = w_pick_idx;
                    w_cnt_next   = '0;
                    w_len_next   = w_len[w_pick_idx];
                    w_last_next  = w_pick_idx;
                end
            end
            ST_XFER: begin
                if (|w_acc) begin
                    w_cnt_next = r_cnt + ONE;
                    if (r_cnt == (r_len - ONE)) begin
                        w_state_next    = ST_GAP;
                        w_gnt_next      = 2'b00;
                        w_pkt_done_next = 1'b1;
                        w_pkt_src_next  = r_idx;
                    end
                end
            end
            ST_GAP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_gnt_next   = 2'b00;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_aclr) begin
        if (i_aclr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grant, packet bookkeeping and status registers.
    always_ff @(posedge i_clk or posedge i_aclr) begin
        if (i_aclr) begin
            r_gnt      <= 2'b00;
            r_idx      <= 1'b0;
            r_cnt      <= '0;
            r_len      <= '0;
            r_last     <= 1'b1;
            r_pkt_done <= 1'b0;
            r_pkt_src  <= 1'b0;
            r_err_len  <= 1'b0;
        end else begin
            r_gnt      <= w_gnt_next;
            r_idx      <= w_idx_next;
            r_cnt      <= w_cnt_next;
            r_len      <= w_len_next;
            r_last     <= w_last_next;
            r_pkt_done <= w_pkt_done_next;
            r_pkt_src  <= w_pkt_src_next;
            r_err_len  <= w_err_len_next;
        end
    end

    // Write data follows the granted requester; zero when nobody owns the port.
    always_comb begin
        w_data = '0;
        if (r_gnt[0]) begin
            w_data = i_data0;
        end else if (r_gnt[1]) begin
            w_data = i_data1;
        end
    end

    assign o_gnt0       = r_gnt[0];
    assign o_gnt1       = r_gnt[1];
    assign o_acc0       = w_acc[0];
    assign o_acc1       = w_acc[1];
    assign o_fifo_wrreq = |w_acc;
    assign o_fifo_data  = w_data;
    assign o_pkt_done   = r_pkt_done;
    assign o_pkt_src    = r_pkt_src;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_err_len    = r_err_len;

endmodule

// File: tb/tb_fmac_fifo_wr_arb.sv
// Testbench for fmac_fifo_wr_arb: directed scenarios plus randomized
// two-requester traffic checked against a packet-level scoreboard.
module tb_fmac_fifo_wr_arb;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 4096;
    localparam int PTR    = 12;
    localparam int MARGIN = 2;

    logic             clk = 1'b0;
    logic             aclr;
    logic             req0, req1;
    logic [PTR:0]     len0, len1;
    logic             valid0, valid1;
    logic [WIDTH-1:0] data0, data1;
    logic [PTR:0]     usedw;
    logic             wrfull;
    logic             gnt0, gnt1, acc0, acc1, wrreq;
    logic [WIDTH-1:0] fdata;
    logic             pkt_done, pkt_src, busy, err_len;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fmac_fifo_wr_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR(PTR), .MARGIN(MARGIN)) dut (
        .i_clk(clk), .i_aclr(aclr),
        .i_req0(req0), .i_req1(req1), .i_len0(len0), .i_len1(len1),
        .i_valid0(valid0), .i_valid1(valid1), .i_data0(data0), .i_data1(data1),
        .o_gnt0(gnt0), .o_gnt1(gnt1), .o_acc0(acc0), .o_acc1(acc1),
        .o_fifo_wrreq(wrreq), .o_fifo_data(fdata),
        .i_fifo_wrusedw(usedw), .i_fifo_wrfull(wrfull),
        .o_pkt_done(pkt_done), .o_pkt_src(pkt_src), .o_busy(busy), .o_err_len(err_len)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        req0 = 0; req1 = 0; len0 = '0; len1 = '0;
        valid0 = 0; valid1 = 0; data0 = '0; data1 = '0;
        usedw = '0; wrfull = 0;
    endtask

    task automatic do_reset();
        aclr = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 aclr = 1'b0;
    endtask

    task automatic test_reset();
        aclr = 1'b1;
        clear_inputs();
        data0 = $urandom | 32'h1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({gnt0, gnt1, acc0, acc1, wrreq, pkt_done, pkt_src, busy, err_len} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 000000000",
                     {gnt0, gnt1, acc0, acc1, wrreq, pkt_done, pkt_src, busy, err_len});
        end
        n_cmp++;
        if (fdata !== '0) begin
            n_bad++;
            $display("FAIL reset_fifo_data: got %h want 0", fdata);
        end
        #1 aclr = 1'b0;
        data0 = '0;
        @(posedge clk); #1;
        $display("reset: done");
    endtask

    task automatic test_single();
        logic [WIDTH-1:0] w [4];
        do_reset();
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        req0 = 1; len0 = 13'd4; valid0 = 1; data0 = w[0];
        @(negedge clk);
        n_cmp++;
        if (gnt0 !== 1'b0) begin n_bad++; $display("FAIL single_early_gnt: got %b want 0", gnt0); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (gnt0 !== 1'b1 || busy !== 1'b1) begin
            n_bad++; $display("FAIL single_gnt: got gnt0=%b busy=%b want 1 1", gnt0, busy);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (wrreq !== 1'b1 || acc0 !== 1'b1 || fdata !== w[k]) begin
                n_bad++;
                $display("FAIL single_word%0d: got wrreq=%b data=%h want 1 %h", k, wrreq, fdata, w[k]);
            end
            $display("single: word %0d data=%h", k, fdata);
            @(posedge clk); #1;
            if (k < 3) data0 = w[k+1]; else valid0 = 0;
            @(negedge clk);
        end
        n_cmp++;
        if (pkt_done !== 1'b1 || pkt_src !== 1'b0 || gnt0 !== 1'b0 || wrreq !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL single_done: got done=%b src=%b gnt0=%b wrreq=%b busy=%b want 1 0 0 0 1",
                     pkt_done, pkt_src, gnt0, wrreq, busy);
        end
        @(posedge clk); #1;
        req0 = 0;
        @(negedge clk);
        n_cmp++;
        if (pkt_done !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL single_after: got done=%b busy=%b want 0 0", pkt_done, busy);
        end
    endtask

    // Packet-level scoreboard: each requester queues its packet words when it
    // raises req; writes must drain exactly the granted requester's queue in
    // order, grants alternate while both have packets, and pkt_done reports
    // the owner once the full length was written.
    task automatic test_traffic(input int n0, input int n1, input int fixed_len,
                                input bit rnd_valid, input int full_at);
        logic [WIDTH-1:0] q0[$];
        logic [WIDTH-1:0] q1[$];
        int left0 = n0, left1 = n1, s0 = 0, s1 = 0, last = 1;
        int cur_src = -1, words = 0, cur_len = 0, done = 0, cyc = 0;
        int cool0 = 0, cool1 = 0, full_left = 0, g, exp_src, l;
        bit drop0 = 0, drop1 = 0, full_used = 0, pg0 = 0, pg1 = 0, exp_acc;
        do_reset();
        while (done < n0 + n1 && cyc < 3000) begin
            if (drop0) begin req0 = 0; drop0 = 0; cool0 = 1; end
            else if (!req0 && left0 > 0) begin
                if (cool0 > 0) cool0--;
                else begin
                    l = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 12));
                    for (int i = 0; i < l; i++) q0.push_back($urandom);
                    len0 = l[PTR:0]; req0 = 1; left0--;
                end
            end
            if (drop1) begin req1 = 0; drop1 = 0; cool1 = 1; end
            else if (!req1 && left1 > 0) begin
                if (cool1 > 0) cool1--;
                else begin
                    l = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 12));
                    for (int i = 0; i < l; i++) q1.push_back($urandom);
                    len1 = l[PTR:0]; req1 = 1; left1--;
                end
            end
            valid0 = (q0.size() > 0) && (!rnd_valid || ($urandom % 4 != 0));
            data0  = valid0 ? q0[0] : $urandom;
            valid1 = (q1.size() > 0) && (!rnd_valid || ($urandom % 4 != 0));
            data1  = valid1 ? q1[0] : $urandom;
            if (full_left > 0) begin wrfull = 1; full_left--; end else wrfull = 0;

            @(negedge clk);
            n_cmp++;
            if (gnt0 && gnt1) begin n_bad++; $display("FAIL gnt_onehot: got 11 want one-hot"); end
            n_cmp++;
            if (wrreq !== (acc0 | acc1)) begin
                n_bad++; $display("FAIL wrreq_vs_acc: got %b want %b", wrreq, acc0 | acc1);
            end
            n_cmp++;
            if (wrfull && wrreq) begin n_bad++; $display("FAIL write_when_full: got 1 want 0"); end
            if ((gnt0 && !pg0) || (gnt1 && !pg1)) begin
                g = gnt1 ? 1 : 0;
                if (s0 < n0 && s1 < n1) exp_src = (last == 0) ? 1 : 0;
                else exp_src = (s0 < n0) ? 0 : 1;
                n_cmp++;
                if (g != exp_src) begin n_bad++; $display("FAIL grant_order: got %0d want %0d", g, exp_src); end
                cur_src = g; words = 0; cur_len = g ? int'(len1) : int'(len0); last = g;
                if (g == 0) s0++; else s1++;
                $display("traffic: grant src=%0d len=%0d", g, cur_len);
            end
            exp_acc = gnt0 & valid0 & ~wrfull;
            n_cmp++;
            if (acc0 !== exp_acc) begin n_bad++; $display("FAIL acc0: got %b want %b", acc0, exp_acc); end
            exp_acc = gnt1 & valid1 & ~wrfull;
            n_cmp++;
            if (acc1 !== exp_acc) begin n_bad++; $display("FAIL acc1: got %b want %b", acc1, exp_acc); end
            if (wrreq) begin
                n_cmp++;
                if (cur_src < 0) begin n_bad++; $display("FAIL write_no_packet: got write want none"); end
                else if (cur_src == 0 && q0.size() > 0) begin
                    if (fdata !== q0[0]) begin n_bad++; $display("FAIL data0: got %h want %h", fdata, q0[0]); end
                    void'(q0.pop_front()); words++;
                end else if (cur_src == 1 && q1.size() > 0) begin
                    if (fdata !== q1[0]) begin n_bad++; $display("FAIL data1: got %h want %h", fdata, q1[0]); end
                    void'(q1.pop_front()); words++;
                end else begin
                    n_bad++; $display("FAIL extra_word: got write want none src=%0d", cur_src);
                end
            end
            if (full_at >= 0 && !full_used && words == full_at && cur_src >= 0) begin
                full_left = 5; full_used = 1;
            end
            if (pkt_done) begin
                n_cmp++;
                if (int'(pkt_src) != cur_src || words != cur_len) begin
                    n_bad++;
                    $display("FAIL pkt_done: got src=%0d words=%0d want src=%0d words=%0d",
                             pkt_src, words, cur_src, cur_len);
                end
                $display("traffic: done src=%0d words=%0d", pkt_src, words);
                if (cur_src == 0) drop0 = 1; else drop1 = 1;
                cur_src = -1; done++;
            end
            pg0 = gnt0; pg1 = gnt1;
            @(posedge clk); #1;
            cyc++;
        end
        n_cmp++;
        if (done != n0 + n1) begin n_bad++; $display("FAIL traffic_timeout: got %0d want %0d", done, n0 + n1); end
        if (full_at >= 0) begin
            n_cmp++;
            if (!full_used) begin n_bad++; $display("FAIL full_not_applied: got 0 want 1"); end
        end
        clear_inputs();
    endtask

    task automatic test_space();
        int w = 0;
        bit seen = 0, got1 = 0;
        do_reset();
        usedw = 13'd4090;
        req0 = 1; len0 = 13'd8; req1 = 1; len1 = 13'd2;
        valid0 = 1; valid1 = 1; data0 = $urandom; data1 = $urandom;
        for (int c = 0; c < 8; c++) begin
            if (c == 5) usedw = 13'd4087;
            @(negedge clk);
            n_cmp++;
            if (gnt0 || gnt1 || wrreq) begin
                n_bad++; $display("FAIL space_block: got gnt=%b%b wrreq=%b want 000", gnt1, gnt0, wrreq);
            end
            @(posedge clk); #1;
        end
        usedw = 13'd4086;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            n_bad++; $display("FAIL space_gnt: got gnt=%b%b want 01", gnt1, gnt0);
        end
        for (int c = 0; c < 20 && !seen; c++) begin
            if (acc0) w++;
            if (pkt_done) seen = 1;
            else begin @(posedge clk); #1; @(negedge clk); end
        end
        n_cmp++;
        if (!seen || w != 8 || pkt_src !== 1'b0) begin
            n_bad++; $display("FAIL space_pkt: got seen=%0d words=%0d src=%b want 1 8 0", seen, w, pkt_src);
        end
        $display("space: req0 packet words=%0d", w);
        @(posedge clk); #1;
        req0 = 0; valid0 = 0;
        for (int c = 0; c < 6 && !got1; c++) begin
            @(negedge clk);
            if (gnt1) got1 = 1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!got1) begin n_bad++; $display("FAIL space_req1: got 0 want gnt1"); end
        clear_inputs();
    endtask

    task automatic test_err_len();
        int w = 0;
        bit seen = 0;
        do_reset();
        req0 = 1; len0 = '0; req1 = 1; len1 = 13'd3; valid1 = 1; data1 = $urandom;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            n_cmp++;
            if (gnt0) begin n_bad++; $display("FAIL err_gnt0: got 1 want 0"); end
            if (acc1) w++;
            @(posedge clk); #1;
            if (pkt_done) begin seen = 1; req1 = 0; valid1 = 0; end
        end
        n_cmp++;
        if (err_len !== 1'b1 || !seen || w != 3) begin
            n_bad++; $display("FAIL err_req1: got err=%b seen=%0d words=%0d want 1 1 3", err_len, seen, w);
        end
        req0 = 0;
        repeat (3) @(posedge clk); #1;
        n_cmp++;
        if (err_len !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err_len); end
        $display("err_len: len0=0 err=%b req1 words=%0d", err_len, w);

        do_reset();
        req0 = 1; len0 = 13'd4095;
        repeat (3) @(posedge clk); #1;
        n_cmp++;
        if (err_len !== 1'b1 || gnt0 !== 1'b0) begin
            n_bad++; $display("FAIL err_len4095: got err=%b gnt0=%b want 1 0", err_len, gnt0);
        end
        do_reset();
        req0 = 1; len0 = 13'd4094;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (gnt0 !== 1'b1 || err_len !== 1'b0) begin
            n_bad++; $display("FAIL len4094: got gnt0=%b err=%b want 1 0", gnt0, err_len);
        end
        $display("err_len: boundary lengths checked");
        do_reset();
    endtask

    task automatic test_aclr();
        int w = 0;
        do_reset();
        req0 = 1; len0 = 13'd10; valid0 = 1; data0 = $urandom | 32'h1;
        req1 = 1; len1 = '0;
        for (int c = 0; c < 12 && w < 3; c++) begin
            @(negedge clk);
            if (acc0) w++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (w != 3 || err_len !== 1'b1 || gnt0 !== 1'b1) begin
            n_bad++; $display("FAIL aclr_pre: got words=%0d err=%b gnt0=%b want 3 1 1", w, err_len, gnt0);
        end
        aclr = 1'b1;
        #1;
        n_cmp++;
        if ({gnt0, gnt1, busy, wrreq, err_len, pkt_done} !== 6'b0 || fdata !== '0) begin
            n_bad++;
            $display("FAIL aclr_mid: got %b data=%h want 000000 0",
                     {gnt0, gnt1, busy, wrreq, err_len, pkt_done}, fdata);
        end
        $display("aclr: asserted after %0d words", w);
        do_reset();
    endtask

    initial begin
        aclr = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_traffic(4, 4, 8, 1'b0, -1);
        test_traffic(5, 5, 0, 1'b1, -1);
        test_space();
        test_err_len();
        test_traffic(1, 0, 16, 1'b0, 6);
        test_aclr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
